// File: rtl/alu_regfile_sequencer.sv
// rtl/alu_regfile_sequencer.sv - command-driven register file and operand stage for a 4-bit ALU
module alu_regfile_sequencer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_kind,
  input  logic [1:0]       cmd_opcode,
  input  logic [1:0]       cmd_dst,
  input  logic [1:0]       cmd_src_a,
  input  logic [1:0]       cmd_src_b,
  input  logic [WIDTH-1:0] cmd_imm,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [1:0]       alu_opcode,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic [1:0]       rsp_dst
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state;
  logic [WIDTH-1:0] regs [4];
  logic [1:0]       dst_q;

  // cmd_ready and rsp_valid are registered copies of "next state is IDLE/RESP"
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      for (int i = 0; i < 4; i++) regs[i] <= '0;
      dst_q      <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_opcode <= '0;
      cmd_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
      rsp_dst    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            if (cmd_kind) begin
              regs[cmd_dst] <= cmd_imm;
              rsp_result    <= cmd_imm;
              rsp_zero      <= (cmd_imm == '0);
              rsp_dst       <= cmd_dst;
              rsp_valid     <= 1'b1;
              state         <= RESP;
            end else begin
              alu_a      <= regs[cmd_src_a];
              alu_b      <= regs[cmd_src_b];
              alu_opcode <= cmd_opcode;
              dst_q      <= cmd_dst;
              state      <= EXEC;
            end
          end
        end
        EXEC: begin
          regs[dst_q] <= alu_result;
          rsp_result  <= alu_result;
          rsp_zero    <= alu_zero;
          rsp_dst     <= dst_q;
          rsp_valid   <= 1'b1;
          state       <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          cmd_ready <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_regfile_sequencer.sv
// tb/tb_alu_regfile_sequencer.sv - directed self-checking bench for alu_regfile_sequencer
module tb_alu_regfile_sequencer;

  logic       clk;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_kind;
  logic [1:0] cmd_opcode;
  logic [1:0] cmd_dst;
  logic [1:0] cmd_src_a;
  logic [1:0] cmd_src_b;
  logic [3:0] cmd_imm;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [1:0] alu_opcode;
  logic [3:0] alu_result;
  logic       alu_zero;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [3:0] rsp_result;
  logic       rsp_zero;
  logic [1:0] rsp_dst;

  int tests_run = 0;
  int tests_failed = 0;

  localparam logic KALU = 1'b0;
  localparam logic KLD  = 1'b1;
  localparam logic [1:0] OP_ADD = 2'd0, OP_SUB = 2'd1, OP_AND = 2'd2, OP_OR = 2'd3;

  alu_regfile_sequencer #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_kind(cmd_kind),
    .cmd_opcode(cmd_opcode), .cmd_dst(cmd_dst), .cmd_src_a(cmd_src_a),
    .cmd_src_b(cmd_src_b), .cmd_imm(cmd_imm),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_zero(rsp_zero), .rsp_dst(rsp_dst)
  );

  // downstream combinational ALU
  always_comb begin
    alu_result = '0;
    case (alu_opcode)
      2'd0: alu_result = alu_a + alu_b;
      2'd1: alu_result = alu_a - alu_b;
      2'd2: alu_result = alu_a & alu_b;
      default: alu_result = alu_a | alu_b;
    endcase
    alu_zero = (alu_result == 4'd0);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic kind, input logic [1:0] op, input logic [1:0] dst,
                       input logic [1:0] sa, input logic [1:0] sb, input logic [3:0] imm);
    cmd_kind = kind; cmd_opcode = op; cmd_dst = dst;
    cmd_src_a = sa; cmd_src_b = sb; cmd_imm = imm;
  endtask

  // returns #1 after the accept edge with cmd_valid dropped
  task automatic send(input string tag, input logic kind, input logic [1:0] op,
                      input logic [1:0] dst, input logic [1:0] sa, input logic [1:0] sb,
                      input logic [3:0] imm);
    int n;
    drive(kind, op, dst, sa, sb, imm);
    cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 20) begin
      step();
      n++;
    end
    check({tag, "_ready"}, cmd_ready, 1);
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic run_cmd(input string tag, input logic kind, input logic [1:0] op,
                         input logic [1:0] dst, input logic [1:0] sa, input logic [1:0] sb,
                         input logic [3:0] imm, input logic [3:0] exp_res, input logic exp_z);
    send(tag, kind, op, dst, sa, sb, imm);
    if (!kind) begin
      check({tag, "_exec_valid"}, rsp_valid, 0);
      check({tag, "_exec_ready"}, cmd_ready, 0);
      step();
    end
    check({tag, "_valid"}, rsp_valid, 1);
    check({tag, "_result"}, rsp_result, exp_res);
    check({tag, "_zero"}, rsp_zero, exp_z);
    check({tag, "_dst"}, rsp_dst, dst);
    step();
    check({tag, "_idle"}, cmd_ready, 1);
  endtask

  initial begin
    rst = 1'b1; rsp_ready = 1'b1; cmd_valid = 1'b0;
    drive(KALU, OP_ADD, 2'd0, 2'd0, 2'd0, 4'd0);
    step(); step();
    rst = 1'b0;
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_result", rsp_result, 0);
    check("rst_alu_a", alu_a, 0);
    run_cmd("add_zero", KALU, OP_ADD, 2'd2, 2'd0, 2'd1, 4'd0, 4'd0, 1'b1);

    run_cmd("ld_r0_5", KLD, OP_ADD, 2'd0, 2'd0, 2'd0, 4'd5, 4'd5, 1'b0);
    run_cmd("ld_r1_3", KLD, OP_ADD, 2'd1, 2'd0, 2'd0, 4'd3, 4'd3, 1'b0);
    run_cmd("add_8", KALU, OP_ADD, 2'd2, 2'd0, 2'd1, 4'd0, 4'd8, 1'b0);

    run_cmd("sub_wrap", KALU, OP_SUB, 2'd3, 2'd1, 2'd0, 4'd0, 4'd14, 1'b0);
    run_cmd("sub_self", KALU, OP_SUB, 2'd3, 2'd0, 2'd0, 4'd0, 4'd0, 1'b1);

    run_cmd("ld_r0_c", KLD, OP_ADD, 2'd0, 2'd0, 2'd0, 4'b1100, 4'b1100, 1'b0);
    run_cmd("ld_r1_a", KLD, OP_ADD, 2'd1, 2'd0, 2'd0, 4'b1010, 4'b1010, 1'b0);
    run_cmd("and", KALU, OP_AND, 2'd2, 2'd0, 2'd1, 4'd0, 4'b1000, 1'b0);
    run_cmd("or", KALU, OP_OR, 2'd3, 2'd0, 2'd1, 4'd0, 4'b1110, 1'b0);
    run_cmd("ld_r2_15", KLD, OP_ADD, 2'd2, 2'd0, 2'd0, 4'd15, 4'd15, 1'b0);
    run_cmd("ld_r3_1", KLD, OP_ADD, 2'd3, 2'd0, 2'd0, 4'd1, 4'd1, 1'b0);
    run_cmd("add_wrap0", KALU, OP_ADD, 2'd0, 2'd2, 2'd3, 4'd0, 4'd0, 1'b1);
    run_cmd("ld_zero", KLD, OP_ADD, 2'd1, 2'd0, 2'd0, 4'd0, 4'd0, 1'b1);
    // dst aliases both sources: 15+15 wraps to 14, then read back
    run_cmd("alias_add", KALU, OP_ADD, 2'd2, 2'd2, 2'd2, 4'd0, 4'd14, 1'b0);
    run_cmd("alias_read", KALU, OP_OR, 2'd0, 2'd2, 2'd2, 4'd0, 4'd14, 1'b0);

    // backpressure with a second command held on the bus
    rsp_ready = 1'b0;
    send("bp_ld", KLD, OP_ADD, 2'd3, 2'd0, 2'd0, 4'd7);
    drive(KLD, OP_ADD, 2'd0, 2'd0, 2'd0, 4'd9);
    cmd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", rsp_valid, 1);
      check("bp_result", rsp_result, 7);
      check("bp_dst", rsp_dst, 3);
      check("bp_cmd_ready", cmd_ready, 0);
      step();
    end
    rsp_ready = 1'b1;
    step();
    check("bp_rel_ready", cmd_ready, 1);
    check("bp_rel_valid", rsp_valid, 0);
    step();
    cmd_valid = 1'b0;
    check("bp_acc_valid", rsp_valid, 1);
    check("bp_acc_result", rsp_result, 9);
    check("bp_acc_dst", rsp_dst, 0);
    step();
    check("bp_after_ready", cmd_ready, 1);
    step();
    check("bp_no_extra", rsp_valid, 0);
    run_cmd("bp_read", KALU, OP_OR, 2'd1, 2'd0, 2'd3, 4'd0, 4'd15, 1'b0);

    // reset during EXEC of r0 = r0 + r1 (9 + 15)
    send("rst_exec", KALU, OP_ADD, 2'd0, 2'd0, 2'd1, 4'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rstx_valid", rsp_valid, 0);
    check("rstx_ready", cmd_ready, 1);
    check("rstx_result", rsp_result, 0);
    run_cmd("rstx_r01", KALU, OP_OR, 2'd2, 2'd0, 2'd1, 4'd0, 4'd0, 1'b1);
    run_cmd("rstx_r23", KALU, OP_OR, 2'd0, 2'd2, 2'd3, 4'd0, 4'd0, 1'b1);

    // reset wins over a simultaneous command
    drive(KLD, OP_ADD, 2'd0, 2'd0, 2'd0, 4'd5);
    cmd_valid = 1'b1;
    rst = 1'b1;
    step();
    rst = 1'b0;
    cmd_valid = 1'b0;
    check("rstc_valid", rsp_valid, 0);
    check("rstc_ready", cmd_ready, 1);
    run_cmd("rstc_r0", KALU, OP_OR, 2'd1, 2'd0, 2'd0, 4'd0, 4'd0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/alu_regfile_sequencer.md
Name: alu_regfile_sequencer

Overview:
Command-driven operand stage that sits directly upstream of the 4-bit combinational ALU (add/sub/and/or, 2-bit opcode, zero flag). Holds a 4-entry x WIDTH register file and accepts commands over a valid/ready handshake. For each command it drives the ALU operands and opcode from registers, captures the ALU result and zero flag, writes the result back, and presents a response over a second valid/ready handshake.

Parameters:
WIDTH, 4, data width of registers, immediates and ALU operands; must equal the ALU operand width.

Ports:
clk  input  1  single clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
cmd_valid  input  1  command present
cmd_ready  output  1  block can accept a command
cmd_kind  input  1  0 = ALU op, 1 = load immediate
cmd_opcode  input  2  ALU opcode: 00 add, 01 sub, 10 and, 11 or (ignored for load)
cmd_dst  input  2  destination register index
cmd_src_a  input  2  operand A register index (ignored for load)
cmd_src_b  input  2  operand B register index (ignored for load)
cmd_imm  input  WIDTH  immediate value (used only by load)
alu_a  output  WIDTH  operand A to ALU
alu_b  output  WIDTH  operand B to ALU
alu_opcode  output  2  opcode to ALU
alu_result  input  WIDTH  ALU result, combinational from alu_a/alu_b/alu_opcode
alu_zero  input  1  ALU zero flag
rsp_valid  output  1  response present
rsp_ready  input  1  consumer accepts response
rsp_result  output  WIDTH  value written to rsp_dst
rsp_zero  output  1  1 when rsp_result == 0
rsp_dst  output  2  register index written

Behaviour:
- Clocking and reset: single clock domain. Reset is synchronous and active-high, sampled on the rising edge of clk.
- Reset values: state IDLE; regs r0..r3 = 0; alu_a, alu_b, alu_opcode = 0; rsp_valid, rsp_result, rsp_zero, rsp_dst = 0; cmd_ready = 1 from the first cycle after reset.
- FSM states: IDLE, EXEC, RESP. cmd_ready = 1 only in IDLE. rsp_valid = 1 only in RESP.
- IDLE, accept when cmd_valid & cmd_ready:
  - ALU op: register alu_a <= r[src_a], alu_b <= r[src_b], alu_opcode <= cmd_opcode, latch dst; go to EXEC.
  - Load: r[dst] <= cmd_imm; rsp_result <= cmd_imm; rsp_zero <= (cmd_imm == 0); rsp_dst <= dst; go to RESP.
- EXEC (exactly 1 cycle): at its closing edge sample alu_result and alu_zero; r[dst] <= alu_result; rsp_result <= alu_result; rsp_zero <= alu_zero; rsp_dst <= dst; go to RESP.
- RESP: hold rsp_* stable while rsp_ready = 0. When rsp_ready = 1, go to IDLE at that edge.
- Latency, accept edge = T: ALU op rsp_valid high from T+2; load from T+1. With rsp_ready tied high, throughput is 1 ALU op per 3 cycles and 1 load per 2 cycles.
- Writeback timing: the register write occurs on the same edge that rsp_valid rises. A following command accepted in IDLE reads the updated value; no bypass is required.
- ALU interface: alu_a, alu_b, alu_opcode are registered and hold their last values outside EXEC.
- Operand aliasing: src_a == src_b is legal. dst equal to a source is legal; operands are read before the write.
- Arithmetic: modulo 2^WIDTH, performed by the ALU. The block itself does no arithmetic except the zero compare for loads.
- Ignored inputs: cmd_* is ignored whenever cmd_ready = 0, including while cmd_valid is asserted. There is no queuing.
- Reset mid-operation: asserting rst in EXEC or RESP abandons the command (no writeback if in EXEC), clears all registers and rsp_valid, and returns to IDLE at that edge.
- Simultaneous rst and cmd_valid: rst wins and the command is not accepted.

Test Plan:
1. Reset 2 cycles -> cmd_ready = 1, rsp_valid = 0, rsp_result = 0. Subsequent ADD r0+r1 -> rsp_result 0, rsp_zero 1.
2. LOAD r0 = 5, LOAD r1 = 3 (each rsp_valid at T+1), then ADD dst = r2 (r0, r1) -> rsp_valid at T+2, rsp_result 8, rsp_zero 0, rsp_dst 2.
3. With r0 = 5, r1 = 3: SUB dst r3 = r1 - r0 -> rsp_result 14 (wrap); SUB r0 - r0 -> rsp_result 0, rsp_zero 1.
4. LOAD r0 = 4'b1100, r1 = 4'b1010; AND -> 4'b1000; OR -> 4'b1110. LOAD r2 = 15, r3 = 1; ADD -> 0, rsp_zero 1. LOAD imm 0 -> rsp_zero 1.
5. Hold rsp_ready = 0 for 5 cycles with cmd_valid = 1 throughout -> rsp_* stable, cmd_ready = 0, no extra command accepted. Release -> IDLE next cycle, then exactly one new accept.
6. Pulse rst during EXEC of ADD r0 = r0 + r1 -> no writeback, all regs 0, rsp_valid 0 on the next cycle, cmd_ready 1.
